// File: rtl/ysyx_22051013_wb_sched_pkg.sv
// Writeback scheduler shared definitions.
// Sizes of the regfile write path and the requester index map.
package ysyx_22051013_wb_sched_pkg;

  localparam int WB_NREQ = 3;
  localparam int WB_XLEN = 64;
  localparam int WB_AW   = 5;
  localparam int WB_NREG = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_CSR = 2'd2
  } wb_src_e;

endpackage

// File: rtl/ysyx_22051013_rr_arb.sv
// Round-robin arbiter: one-hot grant for the first request at or after ptr.
// Ports: clk, rst (async active-low), req[NREQ], grant[NREQ].
module ysyx_22051013_rr_arb #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic          hit;

  always_comb begin
    grant = '0;
    win   = '0;
    idx   = '0;
    sum   = '0;
    hit   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!hit && req[idx]) begin
        hit        = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr <= '0;
    else if (hit)
      ptr <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
  end

endmodule

// File: rtl/ysyx_22051013_wb_sched.sv
// Writeback scheduler: arbitrates writebacks onto the regfile port,
// tracks in-flight rds and stalls issue on RAW/WAW hazards.
module ysyx_22051013_wb_sched
  import ysyx_22051013_wb_sched_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter int XLEN = WB_XLEN,
  parameter int AW   = WB_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_waddr,
  input  logic [NREQ*XLEN-1:0] req_wdata,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd,
  input  logic               iss_rd_en,
  input  logic [AW-1:0]      iss_rs1,
  input  logic               iss_ren1,
  input  logic [AW-1:0]      iss_rs2,
  input  logic               iss_ren2,
  output logic               iss_stall,
  input  logic               flush,
  output logic               rf_wen,
  output logic [AW-1:0]      rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic [WB_NREG-1:0] busy_vec
);

  logic [NREQ-1:0]    grant;
  logic               acc;
  logic [AW-1:0]      sel_a;
  logic [XLEN-1:0]    sel_d;
  logic [WB_NREG-1:0] busy;
  logic [WB_NREG-1:0] busy_nxt;
  logic               set;

  ysyx_22051013_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign acc       = |grant;

  always_comb begin
    sel_a = '0;
    sel_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_waddr[i*AW +: AW];
        sel_d = sel_d | req_wdata[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writes are consumed but never reach the regfile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= acc & (sel_a != '0);
      if (acc) begin
        rf_waddr <= sel_a;
        rf_wdata <= sel_d;
      end
    end
  end

  assign iss_stall = iss_valid &
    ((iss_ren1  & busy[iss_rs1]) |
     (iss_ren2  & busy[iss_rs2]) |
     (iss_rd_en & busy[iss_rd]));

  assign set = iss_valid & iss_rd_en & ~iss_stall;

  // Set after clear so a same-cycle pair leaves rd busy.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen)
      busy_nxt[rf_waddr] = 1'b0;
    if (set)
      busy_nxt[iss_rd] = 1'b1;
    if (flush)
      busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_ysyx_22051013_wb_sched.sv
// Bench for the writeback scheduler: arbitration and write-port
// scoreboard, RAW/WAW stall, x0 handling, flush and reset.
module tb_ysyx_22051013_wb_sched;

  localparam int NREQ = 3;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [63:0] d;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_waddr;
  logic [NREQ*XLEN-1:0] req_wdata;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 iss_rd_en;
  logic [AW-1:0]        iss_rs1;
  logic                 iss_ren1;
  logic [AW-1:0]        iss_rs2;
  logic                 iss_ren2;
  logic                 iss_stall;
  logic                 flush;
  logic                 rf_wen;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [31:0]          busy_vec;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   mptr = 0;
  exp_t q[$];

  ysyx_22051013_wb_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rd_en (iss_rd_en),
    .iss_rs1   (iss_rs1),
    .iss_ren1  (iss_ren1),
    .iss_rs2   (iss_rs2),
    .iss_ren2  (iss_ren2),
    .iss_stall (iss_stall),
    .flush     (flush),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NREQ-1:0] rr_model(
    input logic [NREQ-1:0] v, input int p);
    logic [NREQ-1:0] g;
    int k;
    g = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = (p + i) % NREQ;
      if (g == '0 && v[k]) g[k] = 1'b1;
    end
    return g;
  endfunction

  // Arbitration model: predict grant, push expected regfile write.
  always @(negedge clk) begin : arb_mon
    logic [NREQ-1:0] eg;
    logic [4:0]      w;
    exp_t            e;
    #2;
    if (rst !== 1'b1) begin
      mptr = 0;
      q.delete();
    end else begin
      eg = rr_model(req_valid, mptr);
      nvec++;
      if (req_ready !== eg) begin
        nerr++;
        $display("FAIL arb_grant: req_ready=%b required %b (cyc %0d)",
                 req_ready, eg, cyc);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (eg[i]) begin
          mptr = (i + 1) % NREQ;
          w = req_waddr[i*AW +: AW];
          if (w != 5'd0) begin
            e.cyc = cyc + 1;
            e.a   = w;
            e.d   = req_wdata[i*XLEN +: XLEN];
            q.push_back(e);
          end
        end
      end
    end
  end

  // Write port checker: pop one expectation per rf_wen pulse.
  always @(posedge clk) begin : wr_mon
    exp_t e;
    #1;
    if (rst === 1'b1) begin
      if (rf_wen === 1'b1) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL rf_write: spurious write addr=%0d, required none",
                   rf_waddr);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || rf_waddr !== e.a || rf_wdata !== e.d) begin
            nerr++;
            $display("FAIL rf_write: cyc=%0d a=%0d d=%h required cyc=%0d a=%0d d=%h",
                     cyc, rf_waddr, rf_wdata, e.cyc, e.a, e.d);
          end
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        nvec++;
        nerr++;
        $display("FAIL rf_write: rf_wen=0, required write a=%0d at cyc %0d",
                 q[0].a, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  task automatic idle_iss();
    iss_valid = 1'b0;
    iss_rd    = '0;
    iss_rd_en = 1'b0;
    iss_rs1   = '0;
    iss_ren1  = 1'b0;
    iss_rs2   = '0;
    iss_ren2  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    req_waddr = '0;
    req_wdata = '0;
    idle_iss();
    @(negedge clk);
    #1;
    nvec++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 ||
        rf_wdata !== 64'd0 || busy_vec !== 32'd0) begin
      nerr++;
      $display("FAIL reset_state: wen=%b a=%0d d=%h busy=%h required zeros",
               rf_wen, rf_waddr, rf_wdata, busy_vec);
    end
    @(negedge clk);
    rst = 1'b1;
    req_valid = 3'b111;
    req_waddr = {5'd3, 5'd2, 5'd1};
    req_wdata = {64'h33, 64'h22, 64'h11};
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    iss_rd_en = 1'b1;
    @(negedge clk);
    idle_iss();
    @(posedge clk);
    #3;
    nvec++;
    if (rf_wen !== 1'b1 || busy_vec[3] !== 1'b1) begin
      nerr++;
      $display("FAIL pre_reset: wen=%b busy=%h required wen=1 busy[3]=1",
               rf_wen, busy_vec);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (rf_wen !== 1'b0 || busy_vec !== 32'd0) begin
      nerr++;
      $display("FAIL async_reset: wen=%b busy=%h required 0/0",
               rf_wen, busy_vec);
    end
    @(negedge clk);
    req_waddr = {5'd12, 5'd11, 5'd10};
    req_wdata = {64'hC12, 64'hB11, 64'hA10};
    @(negedge clk);
    rst = 1'b1;
    #1;
    nvec++;
    if (req_ready !== 3'b001) begin
      nerr++;
      $display("FAIL first_grant: req_ready=%b required 001", req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] eg;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      eg = 3'b001 << (i % 3);
      nvec++;
      if (req_ready !== eg) begin
        nerr++;
        $display("FAIL rr_order[%0d]: req_ready=%b required %b",
                 i, req_ready, eg);
      end
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_raw();
    @(negedge clk);
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    iss_rd_en = 1'b1;
    #1;
    nvec++;
    if (iss_stall !== 1'b0) begin
      nerr++;
      $display("FAIL raw_issue: iss_stall=%b required 0", iss_stall);
    end
    @(negedge clk);
    iss_rd_en = 1'b0;
    iss_rs1   = 5'd5;
    iss_ren1  = 1'b1;
    req_valid = 3'b001;
    req_waddr = {5'd0, 5'd0, 5'd5};
    req_wdata = {64'h0, 64'h0, 64'hDEAD};
    #1;
    nvec++;
    if (iss_stall !== 1'b1 || busy_vec[5] !== 1'b1) begin
      nerr++;
      $display("FAIL raw_stall_n: stall=%b busy=%h required 1/busy[5]",
               iss_stall, busy_vec);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    nvec++;
    if (iss_stall !== 1'b1 || busy_vec[5] !== 1'b1 || rf_wen !== 1'b1) begin
      nerr++;
      $display("FAIL raw_stall_n1: stall=%b busy=%h wen=%b required 1/set/1",
               iss_stall, busy_vec, rf_wen);
    end
    @(negedge clk);
    #1;
    nvec++;
    if (iss_stall !== 1'b0 || busy_vec[5] !== 1'b0) begin
      nerr++;
      $display("FAIL raw_release: stall=%b busy=%h required 0/clear",
               iss_stall, busy_vec);
    end
    @(negedge clk);
    idle_iss();
  endtask

  task automatic test_x0();
    @(negedge clk);
    req_valid = 3'b010;
    req_waddr = {5'd0, 5'd0, 5'd0};
    req_wdata = {64'h0, 64'h1, 64'h0};
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    iss_rd_en = 1'b1;
    iss_rs1   = 5'd0;
    iss_ren1  = 1'b1;
    #1;
    nvec++;
    if (req_ready !== 3'b010 || iss_stall !== 1'b0) begin
      nerr++;
      $display("FAIL x0_accept: ready=%b stall=%b required 010/0",
               req_ready, iss_stall);
    end
    @(negedge clk);
    req_valid = '0;
    idle_iss();
    #1;
    nvec++;
    if (rf_wen !== 1'b0 || busy_vec !== 32'd0) begin
      nerr++;
      $display("FAIL x0_nowrite: wen=%b busy=%h required 0/0",
               rf_wen, busy_vec);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    iss_rd_en = 1'b1;
    @(negedge clk);
    iss_rd = 5'd8;
    #1;
    nvec++;
    if (iss_stall !== 1'b0) begin
      nerr++;
      $display("FAIL flush_setup: stall=%b required 0", iss_stall);
    end
    @(negedge clk);
    iss_rd = 5'd5;
    #1;
    nvec++;
    if (iss_stall !== 1'b1 || busy_vec !== 32'h0000_0120) begin
      nerr++;
      $display("FAIL waw_stall: stall=%b busy=%h required 1/00000120",
               iss_stall, busy_vec);
    end
    @(negedge clk);
    iss_valid = 1'b0;
    iss_rd_en = 1'b0;
    iss_rs1   = 5'd5;
    iss_ren1  = 1'b1;
    #1;
    nvec++;
    if (iss_stall !== 1'b0) begin
      nerr++;
      $display("FAIL stall_no_valid: stall=%b required 0", iss_stall);
    end
    @(negedge clk);
    idle_iss();
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    iss_rd_en = 1'b1;
    flush     = 1'b1;
    req_valid = 3'b100;
    req_waddr = {5'd9, 5'd0, 5'd0};
    req_wdata = {64'h99, 64'h0, 64'h0};
    #1;
    nvec++;
    if (busy_vec !== 32'h0000_0120 || iss_stall !== 1'b0) begin
      nerr++;
      $display("FAIL flush_pre: busy=%h stall=%b required 00000120/0",
               busy_vec, iss_stall);
    end
    @(negedge clk);
    flush = 1'b0;
    req_valid = '0;
    idle_iss();
    #1;
    nvec++;
    if (busy_vec !== 32'd0) begin
      nerr++;
      $display("FAIL flush_clear: busy=%h required 00000000", busy_vec);
    end
  endtask

  task automatic test_starvation();
    int          wait_c;
    logic [1:0]  r;
    wait_c = 0;
    req_waddr = {5'd22, 5'd21, 5'd20};
    req_wdata = {64'h2222, 64'h1111, 64'h0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r = 2'($urandom_range(0, 3));
      req_valid = {1'b1, r};
      req_wdata[63:0] = 64'($urandom());
      #1;
      if (req_ready[2] === 1'b1) wait_c = 0;
      else wait_c++;
      nvec++;
      if (wait_c >= NREQ) begin
        nerr++;
        $display("FAIL starvation[%0d]: req2 waited %0d cycles, required < %0d",
                 i, wait_c, NREQ);
      end
    end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #3;
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d writes outstanding, required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_raw();
    test_x0();
    test_flush();
    test_starvation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
